sha256_digest_uart_tx: RTL

Consumer end of the sha256 core's digest interface. It watches DigestReady, captures the 256-bit Digest, and serialises it over a UART 8N1 transmit line to the host. The host therefore receives the hash the core produced. It sits between the sha256 core's Digest/DigestReady outputs and the FPGA TX pin.

---
 rtl/sha256_digest_uart_tx_pkg.sv | 38 +++
 rtl/sha256_digest_uart_tx_byte.sv | 105 ++++++++++
 rtl/sha256_digest_uart_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sha256_digest_uart_tx_pkg.sv
// Purpose : shared constants, FSM encodings and the hex-digit helper for the digest UART transmitter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package sha256_digest_uart_tx_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 115_200;

  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_0       = 8'h30;
  localparam logic [7:0] ASCII_A_LOWER = 8'h61;

  // Character sequencer at the top level. LOAD only precedes the first
  // frame; later frames are loaded during the final stop-bit cycle while
  // the sequencer sits in XMIT.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_XMIT
  } top_state_e;

  // Byte serializer states.
  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_e;

  // 4-bit value to lowercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_0 + {4'h0, nib};
    end
    return ASCII_A_LOWER + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/sha256_digest_uart_tx_byte.sv
// Purpose : 8N1 byte serializer (start bit, 8 data bits LSB first, stop bit).
// Latency : Tx drops for the start bit on the cycle after start_i is accepted.
// Backpressure: start_i is honoured only when idle or in the last stop-bit cycle (done_o), else ignored.
//
// Ports: clk_i/rst_i clock and async active-high reset; start_i/data_i load a
// byte; tx_o serial line (idle high); busy_o frame in progress; done_o high
// during the final cycle of the stop bit, when a new start_i chains seamlessly.
module uart_tx_byte
  import sha256_digest_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  ser_state_e    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          baud_last;

  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SER_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  // tx_q is computed one cycle ahead so the line is a clean register output.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    unique case (state_q)
      SER_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (start_i) begin
          state_d = SER_START;
          sh_d    = data_i;
          tx_d    = 1'b0;
        end
      end
      SER_START: begin
        if (baud_last) begin
          state_d = SER_DATA;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      SER_DATA: begin
        if (baud_last) begin
          sh_d = sh_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = SER_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[1];
          end
        end
      end
      SER_STOP: begin
        if (baud_last) begin
          if (start_i) begin
            state_d = SER_START;
            sh_d    = data_i;
            tx_d    = 1'b0;
          end else begin
            state_d = SER_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != SER_IDLE);
  assign done_o = (state_q == SER_STOP) && baud_last;

endmodule

// File: rtl/sha256_digest_uart_tx.sv
// Purpose : captures the sha256 digest on a DigestReady rising edge and streams it out as UART 8N1.
// Latency : first start bit 2 cycles after the rise; Done 320 (raw) / 650 (hex) bit times + 2 cycles after it.
// Backpressure: none; a rise while busy is dropped and flagged with a one-cycle Overrun pulse.
//
// Ports: Clk, Reset (async active-high); Digest[255:0] (byte [255:248] sent
// first); DigestReady (level, rising edge triggers); Tx serial line (idle
// high); Busy transmission in progress; Done one-cycle pulse after the final
// stop bit; Overrun one-cycle pulse for a dropped request.
module sha256_digest_uart_tx
  import sha256_digest_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ     = CLK_FREQ_DEF,
  parameter int BAUD         = BAUD_DEF,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int HEX_MODE     = 0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [255:0] Digest,
  input  logic         DigestReady,
  output logic         Tx,
  output logic         Busy,
  output logic         Done,
  output logic         Overrun
);

  // Index of the final character: 32 raw bytes or 64 hex digits plus LF.
  localparam logic [6:0] LAST_CHAR = (HEX_MODE != 0) ? 7'd64 : 7'd31;
  localparam int         STEP      = (HEX_MODE != 0) ? 4 : 8;

  top_state_e     state_q, state_d;
  logic           rdy_q;
  logic [255:0]   shift_q, shift_d;
  logic [6:0]     char_q, char_d;
  logic           done_q, done_d;
  logic           rise;
  logic           ser_start, ser_busy, ser_done, ser_tx;
  logic [7:0]     ser_data;
  logic [6:0]     load_idx;

  assign rise = DigestReady & ~rdy_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      shift_q <= '0;
      char_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= DigestReady;
      shift_q <= shift_d;
      char_q  <= char_d;
      done_q  <= done_d;
    end
  end

  // char_q is the index of the frame on the wire; a reload in XMIT loads
  // the following one. The top of shift_q always holds the next unsent
  // byte/nibble.
  assign load_idx = (state_q == ST_LOAD) ? char_q : char_q + 7'd1;

  always_comb begin
    ser_data = shift_q[255:248];
    if (HEX_MODE != 0) begin
      ser_data = (load_idx == LAST_CHAR) ? ASCII_LF : hex_ascii(shift_q[255:252]);
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    char_d    = char_q;
    done_d    = 1'b0;
    ser_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          shift_d = Digest;
          char_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ser_start = 1'b1;
        shift_d   = shift_q << STEP;
        state_d   = ST_XMIT;
      end
      ST_XMIT: begin
        // Reload during the last stop cycle so frames run back to back.
        if (ser_done) begin
          if (char_q == LAST_CHAR) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            ser_start = 1'b1;
            shift_d   = shift_q << STEP;
            char_d    = char_q + 7'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .start_i (ser_start),
    .data_i  (ser_data),
    .tx_o    (ser_tx),
    .busy_o  (ser_busy),
    .done_o  (ser_done)
  );

  assign Tx      = ser_tx;
  assign Busy    = (state_q != ST_IDLE) | ser_busy;
  assign Done    = done_q;
  assign Overrun = rise & (state_q != ST_IDLE);

endmodule
